// File: rtl/mem_slice_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Shared types and field positions for the MEM pipeline stage.
//   - mem_state_t : access sequencer states (IDLE, BUSY, DONE, ERR)
//   - M_READ/M_WRITE      : bit positions inside the 2-bit M control field
//   - WB_REGWRITE/WB_MEMTOREG : bit positions inside the 7-bit WB field
//   - is_mem_op / is_read : decode helpers for the M field
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int WB_W = 7;
  localparam int M_W  = 2;
  localparam int RD_W = 4;

  // Any memory access at all.
  function automatic logic is_mem_op(input logic [M_W-1:0] m);
    return m[M_READ] | m[M_WRITE];
  endfunction

  // A read is only performed when the write bit is clear: write wins.
  function automatic logic is_read(input logic [M_W-1:0] m);
    return m[M_READ] & ~m[M_WRITE];
  endfunction

endpackage

// File: rtl/mem_slice_if.sv
// -----------------------------------------------------------------------------
// mem_slice_if
//   Data-memory request/ready bus between the MEM stage and the data memory.
//   Ports (signals):
//     mem_addr  : access address            (master -> slave)
//     mem_wdata : store data                (master -> slave)
//     mem_req   : access request            (master -> slave)
//     mem_we    : 1 = write, 0 = read       (master -> slave)
//     mem_rdata : read data, valid w/ ready (slave -> master)
//     mem_ready : access complete           (slave -> master)
//   Modports: master (MEM stage), slave (memory).
// -----------------------------------------------------------------------------
interface mem_slice_if #(
  parameter int DW = 16
);
  import mem_pkg::*;

  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_req,
    output mem_we,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_req,
    input  mem_we,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mem_slice_wait_ctr.sv
// -----------------------------------------------------------------------------
// mem_wait_ctr
//   Watchdog counter for the MEM stage. Counts cycles spent waiting on the
//   data memory and flags when the last permitted wait cycle is reached.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     clr      : return count to zero
//     en       : advance count by one
//     expire   : count has reached MAX_WAIT-1
// -----------------------------------------------------------------------------
module mem_wait_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  import mem_pkg::*;

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign expire = (wait_cnt == LAST);

endmodule

// File: rtl/mem_slice.sv
// -----------------------------------------------------------------------------
// mem_slice
//   MEM pipeline stage. Registers the execute-stage outputs, performs a
//   data-memory access over a req/ready handshake, stalls upstream while the
//   access is outstanding and hands a single-shot writeback bundle to WB.
//   A watchdog turns a memory that never answers into a sticky error.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     flush           : load a bubble instead of the EX outputs
//     WB_in, M_in     : writeback / memory control from EX
//     addr_in, data_in, result_in, rd_in : EX datapath outputs
//     mem             : data-memory bus (master side)
//     WB, wb_data, rd, wb_valid : writeback bundle to WB stage
//     stall           : freeze upstream and this stage's input register
//     mem_err         : sticky timeout flag
//     fwd_we, fwd_rd, fwd_data : forwarding-unit view of the bundle
// -----------------------------------------------------------------------------
module mem_slice
  import mem_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            MAX_WAIT = 8,
  parameter logic [DW-1:0] ERR_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WB_W-1:0]  WB_in,
  input  logic [M_W-1:0]   M_in,
  input  logic [DW-1:0]    addr_in,
  input  logic [DW-1:0]    data_in,
  input  logic [DW-1:0]    result_in,
  input  logic [RD_W-1:0]  rd_in,
  mem_slice_if.master      mem,
  output logic [WB_W-1:0]  WB,
  output logic [DW-1:0]    wb_data,
  output logic [RD_W-1:0]  rd,
  output logic             wb_valid,
  output logic             stall,
  output logic             mem_err,
  output logic             fwd_we,
  output logic [RD_W-1:0]  fwd_rd,
  output logic [DW-1:0]    fwd_data
);

  logic [WB_W-1:0] WB_q;
  logic [M_W-1:0]  M_q;
  logic [DW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   result_q;
  logic [RD_W-1:0] rd_q;
  logic [DW-1:0]   rdata_q;

  mem_state_t state, state_nxt;

  logic mem_op;
  logic rd_op;
  logic mem_req;
  logic cnt_clr;
  logic cnt_en;
  logic expire;
  logic cap_rd;
  logic to_err;
  logic sel_mem;

  assign mem_op = is_mem_op(M_q);
  assign rd_op  = is_read(M_q);

  // ---- stage input register (EX -> MEM) ----
  // Holds while stalled so the committed access sees stable operands; flush
  // only has to kill the control fields, the rest become don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_q     <= '0;
      M_q      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (!stall) begin
      WB_q     <= flush ? '0 : WB_in;
      M_q      <= flush ? '0 : M_in;
      addr_q   <= addr_in;
      data_q   <= data_in;
      result_q <= result_in;
      rd_q     <= rd_in;
    end
  end

  // ---- access sequencer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    stall     = 1'b0;
    wb_valid  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cap_rd    = 1'b0;
    to_err    = 1'b0;
    sel_mem   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_req = 1'b1;
          stall   = 1'b1;
          if (mem.mem_ready) begin
            cap_rd    = rd_op;
            state_nxt = DONE;
          end else begin
            cnt_en    = 1'b1;
            state_nxt = BUSY;
          end
        end else begin
          wb_valid = 1'b1;
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem.mem_ready) begin
          cap_rd    = rd_op;
          state_nxt = DONE;
        end else if (expire) begin
          to_err    = 1'b1;
          state_nxt = ERR;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE, ERR: begin
        // Loaded data exists only when a read was performed; writes (including
        // the both-bits-set case) return the ALU result.
        wb_valid  = 1'b1;
        sel_mem   = WB_q[WB_MEMTOREG] & rd_op;
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  mem_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (expire)
  );

  // ---- load data / error capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (cap_rd) begin
      rdata_q <= mem.mem_rdata;
    end else if (to_err) begin
      rdata_q <= ERR_DATA;
    end
  end

  // Set on entry to ERR so the flag is already visible alongside the
  // substituted writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (to_err) begin
      mem_err <= 1'b1;
    end
  end

  // ---- memory bus and writeback outputs ----
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = data_q;
  assign mem.mem_we    = M_q[M_WRITE];
  assign mem.mem_req   = mem_req;

  // WB is gated so a stalled instruction can never write the register file
  // on more than one cycle.
  assign WB       = wb_valid ? WB_q : '0;
  assign wb_data  = sel_mem ? rdata_q : result_q;
  assign rd       = rd_q;
  assign fwd_we   = WB_q[WB_REGWRITE] & wb_valid;
  assign fwd_rd   = rd_q;
  assign fwd_data = wb_data;

endmodule

// File: tb/tb_mem_slice.sv
module tb_mem_slice;
  import mem_pkg::*;

  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [6:0]       WB_in;
  logic [1:0]       M_in;
  logic [DW-1:0]    addr_in, data_in, result_in;
  logic [3:0]       rd_in;
  logic [6:0]       WB;
  logic [DW-1:0]    wb_data, fwd_data;
  logic [3:0]       rd, fwd_rd;
  logic             wb_valid, stall, mem_err, fwd_we;

  int checks = 0;
  int errors = 0;

  mem_slice_if #(.DW(DW)) mem_bus ();

  mem_slice #(
    .DW       (DW),
    .MAX_WAIT (8),
    .ERR_DATA (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .WB_in     (WB_in),
    .M_in      (M_in),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .result_in (result_in),
    .rd_in     (rd_in),
    .mem       (mem_bus),
    .WB        (WB),
    .wb_data   (wb_data),
    .rd        (rd),
    .wb_valid  (wb_valid),
    .stall     (stall),
    .mem_err   (mem_err),
    .fwd_we    (fwd_we),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic ex(input logic [6:0] wb, input logic [1:0] m, input logic [15:0] a,
                    input logic [15:0] d, input logic [15:0] r, input logic [3:0] rdv);
    WB_in = wb; M_in = m; addr_in = a; data_in = d; result_in = r; rd_in = rdv;
  endtask

  task automatic bubble();
    ex(7'h00, 2'b00, 16'h0, 16'h0, 16'h0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; bubble();
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 16'h0;
    cyc(); cyc();
    #1;
    chk("rst_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall},    32'd0);
    chk("rst_valid", {31'b0, wb_valid}, 32'd1);
    chk("rst_wb",    {25'b0, WB},       32'h0);
    chk("rst_data",  {16'b0, wb_data},  32'h0);
    chk("rst_err",   {31'b0, mem_err},  32'd0);
    rst = 1'b0;

    // ALU op
    ex(7'h01, 2'b00, 16'h0010, 16'h0, 16'h1234, 4'd3);
    cyc(); #1;
    chk("alu_valid", {31'b0, wb_valid}, 32'd1);
    chk("alu_wb",    {25'b0, WB},       32'h01);
    chk("alu_data",  {16'b0, wb_data},  32'h1234);
    chk("alu_rd",    {28'b0, rd},       32'd3);
    chk("alu_stall", {31'b0, stall},    32'd0);
    chk("alu_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    chk("alu_fwdwe", {31'b0, fwd_we},   32'd1);

    // Zero-wait load
    ex(7'h03, 2'b10, 16'h0040, 16'h0, 16'h5555, 4'd5);
    cyc();
    bubble();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 16'hBEEF;
    #1;
    chk("ld0_stall", {31'b0, stall},           32'd1);
    chk("ld0_req",   {31'b0, mem_bus.mem_req}, 32'd1);
    chk("ld0_we",    {31'b0, mem_bus.mem_we},  32'd0);
    chk("ld0_addr",  {16'b0, mem_bus.mem_addr}, 32'h0040);
    chk("ld0_wbz",   {25'b0, WB},              32'h0);
    chk("ld0_vld0",  {31'b0, wb_valid},        32'd0);
    cyc();
    mem_bus.mem_ready = 1'b0;
    #1;
    chk("ld0_stall1", {31'b0, stall},    32'd0);
    chk("ld0_valid",  {31'b0, wb_valid}, 32'd1);
    chk("ld0_data",   {16'b0, wb_data},  32'hBEEF);
    chk("ld0_fwdrd",  {28'b0, fwd_rd},   32'd5);
    chk("ld0_wb",     {25'b0, WB},       32'h03);
    chk("ld0_fwdd",   {16'b0, fwd_data}, 32'hBEEF);

    // Store, ready on the 4th request cycle; upstream changes during stall
    ex(7'h00, 2'b01, 16'h0100, 16'h00AA, 16'h7777, 4'd2);
    cyc();
    ex(7'h01, 2'b00, 16'h0F0F, 16'hF0F0, 16'h9999, 4'd9);
    for (int i = 0; i < 4; i++) begin
      mem_bus.mem_ready = (i == 3);
      #1;
      chk($sformatf("st_req%0d", i),   {31'b0, mem_bus.mem_req},   32'd1);
      chk($sformatf("st_we%0d", i),    {31'b0, mem_bus.mem_we},    32'd1);
      chk($sformatf("st_addr%0d", i),  {16'b0, mem_bus.mem_addr},  32'h0100);
      chk($sformatf("st_wdata%0d", i), {16'b0, mem_bus.mem_wdata}, 32'h00AA);
      chk($sformatf("st_stall%0d", i), {31'b0, stall},             32'd1);
      chk($sformatf("st_vld%0d", i),   {31'b0, wb_valid},          32'd0);
      cyc();
    end
    mem_bus.mem_ready = 1'b0;
    #1;
    chk("st_done_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    chk("st_done_valid", {31'b0, wb_valid},        32'd1);
    chk("st_done_rd",    {28'b0, rd},              32'd2);
    chk("st_done_data",  {16'b0, wb_data},         32'h7777);
    cyc(); #1;
    chk("st_next_data",  {16'b0, wb_data},  32'h9999);
    chk("st_next_rd",    {28'b0, rd},       32'd9);
    chk("st_next_wb",    {25'b0, WB},       32'h01);

    // Timeout
    ex(7'h03, 2'b10, 16'h0200, 16'h0, 16'h1111, 4'd6);
    cyc();
    ex(7'h01, 2'b00, 16'h0, 16'h0, 16'h2222, 4'd7);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("to_req%0d", i), {31'b0, mem_bus.mem_req}, 32'd1);
      chk($sformatf("to_err%0d", i), {31'b0, mem_err},         32'd0);
      cyc();
    end
    #1;
    chk("to_erreq",  {31'b0, mem_bus.mem_req}, 32'd0);
    chk("to_valid",  {31'b0, wb_valid},        32'd1);
    chk("to_data",   {16'b0, wb_data},         32'h0000);
    chk("to_flag",   {31'b0, mem_err},         32'd1);
    chk("to_wb",     {25'b0, WB},              32'h03);
    chk("to_rd",     {28'b0, rd},              32'd6);
    cyc(); #1;
    bubble();
    chk("to_alu_data", {16'b0, wb_data}, 32'h2222);
    chk("to_flag2",    {31'b0, mem_err}, 32'd1);

    // Flush during ALU op
    ex(7'h01, 2'b00, 16'h0, 16'h0, 16'h3333, 4'd8);
    flush = 1'b1;
    cyc(); #1;
    flush = 1'b0;
    chk("fl_alu_wb",  {25'b0, WB},       32'h0);
    chk("fl_alu_vld", {31'b0, wb_valid}, 32'd1);
    chk("fl_alu_fwe", {31'b0, fwd_we},   32'd0);

    // Flush during BUSY load is ignored
    ex(7'h03, 2'b10, 16'h0300, 16'h0, 16'h4444, 4'd10);
    cyc();
    bubble();
    flush = 1'b1;
    cyc(); #1;
    chk("fl_busy_stall", {31'b0, stall}, 32'd1);
    cyc();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 16'hCAFE;
    cyc();
    mem_bus.mem_ready = 1'b0;
    flush = 1'b0;
    #1;
    chk("fl_ld_valid", {31'b0, wb_valid}, 32'd1);
    chk("fl_ld_wb",    {25'b0, WB},       32'h03);
    chk("fl_ld_data",  {16'b0, wb_data},  32'hCAFE);
    chk("fl_ld_rd",    {28'b0, rd},       32'd10);
    chk("fl_ld_err",   {31'b0, mem_err},  32'd1);
    cyc(); #1;
    chk("fl_after_wb", {25'b0, WB}, 32'h0);

    // Both M bits: write wins, result written back
    ex(7'h03, 2'b11, 16'h0500, 16'h0055, 16'h6666, 4'd11);
    cyc();
    bubble();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
    #1;
    chk("both_we",  {31'b0, mem_bus.mem_we},  32'd1);
    chk("both_req", {31'b0, mem_bus.mem_req}, 32'd1);
    cyc();
    mem_bus.mem_ready = 1'b0;
    #1;
    chk("both_data", {16'b0, wb_data}, 32'h6666);
    chk("both_vld",  {31'b0, wb_valid}, 32'd1);
    cyc();

    // Reset in the middle of a BUSY load
    ex(7'h03, 2'b10, 16'h0600, 16'h0, 16'h8888, 4'd12);
    cyc();
    bubble();
    cyc(); #1;
    chk("rb_busy_req", {31'b0, mem_bus.mem_req}, 32'd1);
    rst = 1'b1;
    cyc(); #1;
    rst = 1'b0;
    chk("rb_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    chk("rb_stall", {31'b0, stall},           32'd0);
    chk("rb_wb",    {25'b0, WB},              32'h0);
    chk("rb_err",   {31'b0, mem_err},         32'd0);
    chk("rb_vld",   {31'b0, wb_valid},        32'd1);

    // Normal operation resumes
    ex(7'h01, 2'b00, 16'h0, 16'h0, 16'hABCD, 4'd1);
    cyc(); #1;
    chk("post_data", {16'b0, wb_data}, 32'hABCD);
    chk("post_rd",   {28'b0, rd},      32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
